spi_slave_host_fifo: RTL and testbench

//  Byte-buffering stage between the host and the SPI slave-mode interface of the SPI chip.
//  TX FIFO: host writes bytes; the block hands them one at a time to the slave core as tx_valid/tx_data.
//  RX FIFO: captures every rx_valid/rx_data byte from the core; the host reads it at its own pace.

---
 rtl/spi_slave_host_fifo.sv | 145 ++++++++++++++
 tb/tb_spi_slave_host_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_host_fifo.sv
// spi_slave_host_fifo: byte buffering between a host push/pop interface and
// the slave-mode core of the SPI chip. The TX FIFO feeds a one-byte loader
// that hands bytes to the core; the RX FIFO captures every exchanged byte.
// Optional feature macro: SPI_HOST_FIFO_STATUS_EN adds sticky status flags
// {underrun, rx_ovf, tx_ovf} on status_o, cleared by status_clr_i.
module spi_slave_host_fifo #(
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter logic [7:0]  TX_IDLE_BYTE = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  host_tx_wr,
  input  logic [7:0]            host_tx_data,
  output logic                  host_tx_full,
  output logic [DEPTH_LOG2:0]   host_tx_level,
  input  logic                  host_rx_rd,
  output logic [7:0]            host_rx_data,
  output logic                  host_rx_empty,
  output logic [DEPTH_LOG2:0]   host_rx_level,
  input  logic                  flush_i,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data
`ifdef SPI_HOST_FIFO_STATUS_EN
  ,
  output logic [2:0]            status_o,
  input  logic                  status_clr_i
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOADED = 1'b1;

  logic [7:0]          tx_mem [DEPTH];
  logic [7:0]          rx_mem [DEPTH];
  logic [DEPTH_LOG2:0] tx_wr_ptr, tx_rd_ptr;
  logic [DEPTH_LOG2:0] rx_wr_ptr, rx_rd_ptr;
  logic                state;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic load_pop, tx_push, rx_pop, rx_push;

  // Occupancy flags: pointers carry one extra wrap bit, so full means the
  // index bits match while the wrap bits differ.
  always_comb begin
    tx_empty = (tx_wr_ptr == tx_rd_ptr);
    tx_full  = (tx_wr_ptr[DEPTH_LOG2] != tx_rd_ptr[DEPTH_LOG2]) &&
               (tx_wr_ptr[DEPTH_LOG2-1:0] == tx_rd_ptr[DEPTH_LOG2-1:0]);
    rx_empty = (rx_wr_ptr == rx_rd_ptr);
    rx_full  = (rx_wr_ptr[DEPTH_LOG2] != rx_rd_ptr[DEPTH_LOG2]) &&
               (rx_wr_ptr[DEPTH_LOG2-1:0] == rx_rd_ptr[DEPTH_LOG2-1:0]);
  end

  // Push/pop qualification. An rx_valid seen while idle is an underrun and
  // suppresses the load that cycle; a push into a full FIFO only lands when
  // the same FIFO is popped in the same cycle.
  always_comb begin
    load_pop = (state == ST_IDLE) && !tx_empty && !rx_valid && !flush_i;
    tx_push  = host_tx_wr && !flush_i && (!tx_full || load_pop);
    rx_pop   = host_rx_rd && !rx_empty && !flush_i;
    rx_push  = rx_valid && !flush_i && (!rx_full || rx_pop);
  end

  // Storage arrays need no reset: the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr[DEPTH_LOG2-1:0]] <= host_tx_data;
    if (rx_push) rx_mem[rx_wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
  end

  // FIFO pointers; flush empties both FIFOs in one cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else if (flush_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (tx_push)  tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (load_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push)  rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  // Loader: pops one byte onto tx_data with a one-cycle tx_valid pulse, then
  // waits for the core to exchange it before loading the next one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= TX_IDLE_BYTE;
    end else begin
      tx_valid <= load_pop;
      if (flush_i) begin
        state <= ST_IDLE;
      end else if (load_pop) begin
        tx_data <= tx_mem[tx_rd_ptr[DEPTH_LOG2-1:0]];
        state   <= ST_LOADED;
      end else if ((state == ST_LOADED) && rx_valid) begin
        state <= ST_IDLE;
      end
    end
  end

  // Host-side status views.
  always_comb begin
    host_tx_full  = tx_full;
    host_tx_level = tx_wr_ptr - tx_rd_ptr;
    host_rx_empty = rx_empty;
    host_rx_level = rx_wr_ptr - rx_rd_ptr;
    host_rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[DEPTH_LOG2-1:0]];
  end

`ifdef SPI_HOST_FIFO_STATUS_EN
  logic [2:0] status_q;
  logic [2:0] status_ev;

  // Events: bit2 underrun (rx_valid while idle), bit1 dropped RX byte,
  // bit0 dropped host push. Nothing counts during a flush cycle.
  always_comb begin
    status_ev[2] = rx_valid && !flush_i && (state == ST_IDLE);
    status_ev[1] = rx_valid && !flush_i && !rx_push;
    status_ev[0] = host_tx_wr && !flush_i && !tx_push;
  end

  // Sticky flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) status_q <= 3'b000;
    else         status_q <= (status_q & ~{3{status_clr_i}}) | status_ev;
  end

  assign status_o = status_q;
`else
  // Drop and underrun events are silently ignored in this build.
`endif

endmodule

// File: tb/tb_spi_slave_host_fifo.sv
// Self-checking bench for spi_slave_host_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_spi_slave_host_fifo;

  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk_i = 1'b0;
  logic                rstn_i;
  logic                host_tx_wr;
  logic [7:0]          host_tx_data;
  logic                host_tx_full;
  logic [DEPTH_LOG2:0] host_tx_level;
  logic                host_rx_rd;
  logic [7:0]          host_rx_data;
  logic                host_rx_empty;
  logic [DEPTH_LOG2:0] host_rx_level;
  logic                flush_i;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                rx_valid;
  logic [7:0]          rx_data;
`ifdef SPI_HOST_FIFO_STATUS_EN
  logic [2:0]          status_o;
  logic                status_clr_i;
`endif

  always #5 clk_i = ~clk_i;

  spi_slave_host_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .TX_IDLE_BYTE(8'hFF)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .host_tx_wr   (host_tx_wr),
    .host_tx_data (host_tx_data),
    .host_tx_full (host_tx_full),
    .host_tx_level(host_tx_level),
    .host_rx_rd   (host_rx_rd),
    .host_rx_data (host_rx_data),
    .host_rx_empty(host_rx_empty),
    .host_rx_level(host_rx_level),
    .flush_i      (flush_i),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data)
`ifdef SPI_HOST_FIFO_STATUS_EN
    ,
    .status_o     (status_o),
    .status_clr_i (status_clr_i)
`endif
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: host-visible FIFO contents, whether a byte is
  // outstanding at the core, and the last byte handed over.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         mLoaded;
  bit         mTxValid;
  logic [7:0] mTxData;
`ifdef SPI_HOST_FIFO_STATUS_EN
  logic [2:0] mFlags;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic modelReset();
    txq.delete();
    rxq.delete();
    mLoaded  = 0;
    mTxValid = 0;
    mTxData  = 8'hFF;
`ifdef SPI_HOST_FIFO_STATUS_EN
    mFlags   = 3'b000;
`endif
  endtask

  task automatic checkAll();
    checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, mTxValid});
    checkOutput("tx_data", {24'd0, tx_data}, {24'd0, mTxData});
    checkOutput("tx_full", {31'd0, host_tx_full}, (txq.size() == DEPTH) ? 32'd1 : 32'd0);
    checkOutput("tx_level", {28'd0, host_tx_level}, txq.size());
    checkOutput("rx_empty", {31'd0, host_rx_empty}, (rxq.size() == 0) ? 32'd1 : 32'd0);
    checkOutput("rx_level", {28'd0, host_rx_level}, rxq.size());
    if (rxq.size() != 0) checkOutput("rx_head", {24'd0, host_rx_data}, {24'd0, rxq[0]});
`ifdef SPI_HOST_FIFO_STATUS_EN
    checkOutput("status", {29'd0, status_o}, {29'd0, mFlags});
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] wdata, input logic rd,
                               input logic rv, input logic [7:0] rdata,
                               input logic fl, input logic clr);
    bit popTx, popRx, txAcc, rxAcc;
    logic [2:0] ev;
    host_tx_wr   = wr;
    host_tx_data = wdata;
    host_rx_rd   = rd;
    rx_valid     = rv;
    rx_data      = rdata;
    flush_i      = fl;
`ifdef SPI_HOST_FIFO_STATUS_EN
    status_clr_i = clr;
`endif
    ev = 3'b000;
    if (fl) begin
      txq.delete();
      rxq.delete();
      mLoaded  = 0;
      mTxValid = 0;
    end else begin
      popTx = !mLoaded && txq.size() != 0 && !rv;
      popRx = rd && rxq.size() != 0;
      txAcc = wr && (txq.size() < DEPTH || popTx);
      rxAcc = rv && (rxq.size() < DEPTH || popRx);
      ev = {rv && !mLoaded, rv && !rxAcc, wr && !txAcc};
      mTxValid = popTx;
      if (popTx) begin
        mTxData = txq.pop_front();
        mLoaded = 1;
      end else if (mLoaded && rv) begin
        mLoaded = 0;
      end
      if (popRx) void'(rxq.pop_front());
      if (txAcc) txq.push_back(wdata);
      if (rxAcc) rxq.push_back(rdata);
    end
`ifdef SPI_HOST_FIFO_STATUS_EN
    mFlags = (mFlags & ~{3{clr}}) | ev;
`else
    if (clr && ev != 3'b000) ev = 3'b000;
`endif
    @(posedge clk_i);
    @(negedge clk_i);
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tx_data"}, {24'd0, tx_data}, 32'hFF);
    checkOutput({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    checkOutput({tag, "_rx_empty"}, {31'd0, host_rx_empty}, 32'd1);
    checkOutput({tag, "_tx_level"}, {28'd0, host_tx_level}, 32'd0);
    checkOutput({tag, "_rx_level"}, {28'd0, host_rx_level}, 32'd0);
  endtask

  initial begin
    rstn_i       = 1'b0;
    host_tx_wr   = 1'b0;
    host_tx_data = 8'h00;
    host_rx_rd   = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    flush_i      = 1'b0;
`ifdef SPI_HOST_FIFO_STATUS_EN
    status_clr_i = 1'b0;
`endif
    modelReset();
    repeat (3) @(negedge clk_i);
    checkResetValues("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Underrun right after reset: tx_data must stay at the idle byte.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("underrun_tx_data", {24'd0, tx_data}, 32'hFF);
    idleCycle();
    checkOutput("underrun_no_pulse", {31'd0, tx_valid}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Single byte: pulse two cycles after the push, then no repeat.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idleCycle();
    checkOutput("a5_pulse", {31'd0, tx_valid}, 32'd1);
    checkOutput("a5_data", {24'd0, tx_data}, 32'hA5);
    repeat (3) idleCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Two bytes exchanged for 3C twice.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("seq_first", {24'd0, tx_data}, 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("seq_second", {24'd0, tx_data}, 32'h22);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    checkOutput("rx_level_two", {28'd0, host_rx_level}, 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rx_level_zero", {28'd0, host_rx_level}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Ten pushes with the loader blocked: ninth fills, tenth is dropped.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("tx_full_after_ten", {31'd0, host_tx_full}, 32'd1);
    checkOutput("tx_level_after_ten", {28'd0, host_tx_level}, 32'd8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // RX full plus simultaneous read and rx_valid.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
    checkOutput("rx_full_level", {28'd0, host_rx_level}, 32'd8);
    checkOutput("rx_full_head", {24'd0, host_rx_data}, 32'hB1);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 rstn_i = 1'b0;
        #1 checkResetValues("midreset");
        modelReset();
        @(negedge clk_i);
        rstn_i = 1'b1;
      end
      applyStimulus(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, 8'($urandom),
                    ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, 8'($urandom),
                    ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
